// File: rtl/demux_buf.sv
// Steers one valid/ready word stream into one of two output channels,
// each backed by its own small FIFO so one stalled consumer never blocks or corrupts the other.
module demux_buf #(
    parameter int unsigned N     = 17,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     demux_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             choose,
    output logic [N-1:0]     demux_out0,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [N-1:0]     demux_out1,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [OCC_W-1:0] occ0,
    output logic [OCC_W-1:0] occ1
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]     mem_q [2][DEPTH];
    logic [PW-1:0]    wr_ptr_q [2];
    logic [PW-1:0]    rd_ptr_q [2];
    logic [OCC_W-1:0] occ_q [2];

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] out_ready;
    logic [1:0] push;
    logic [1:0] pop;

    assign out_ready = {out1_ready, out0_ready};

    // in_ready looks only at registered occupancy: a same-cycle pop never frees space.
    always_comb begin
        full  = '0;
        empty = '0;
        for (int c = 0; c < 2; c++) begin
            full[c]  = (occ_q[c] == OCC_W'(DEPTH));
            empty[c] = (occ_q[c] == '0);
        end
    end

    assign in_ready = ~full[choose];

    always_comb begin
        push = '0;
        pop  = '0;
        for (int c = 0; c < 2; c++) begin
            push[c] = in_valid & in_ready & (choose == 1'(c));
            pop[c]  = ~empty[c] & out_ready[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                occ_q[c]    <= '0;
                for (int e = 0; e < int'(DEPTH); e++) begin
                    mem_q[c][e] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    mem_q[c][wr_ptr_q[c]] <= demux_in;
                    wr_ptr_q[c]           <= wr_ptr_q[c] + PW'(1);
                end
                if (pop[c]) begin
                    rd_ptr_q[c] <= rd_ptr_q[c] + PW'(1);
                end
                unique case ({push[c], pop[c]})
                    2'b10:   occ_q[c] <= occ_q[c] + OCC_W'(1);
                    2'b01:   occ_q[c] <= occ_q[c] - OCC_W'(1);
                    default: occ_q[c] <= occ_q[c];
                endcase
            end
        end
    end

    // Outputs come from registered FIFO state only; head word is whatever sits at rd_ptr.
    assign demux_out0 = mem_q[0][rd_ptr_q[0]];
    assign demux_out1 = mem_q[1][rd_ptr_q[1]];
    assign out0_valid = ~empty[0];
    assign out1_valid = ~empty[1];
    assign occ0       = occ_q[0];
    assign occ1       = occ_q[1];

endmodule

// File: tb/tb_demux_buf.sv
// Directed bench for demux_buf: reset, steering, backpressure, push/pop overlap,
// pointer wrap and mid-operation reset.
module tb_demux_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [16:0] demux_in;
    logic        in_valid;
    logic        in_ready;
    logic        choose;
    logic [16:0] demux_out0;
    logic        out0_valid;
    logic        out0_ready;
    logic [16:0] demux_out1;
    logic        out1_valid;
    logic        out1_ready;
    logic [1:0]  occ0;
    logic [1:0]  occ1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_buf #(
        .N     (17),
        .DEPTH (2),
        .OCC_W (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .demux_in   (demux_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .choose     (choose),
        .demux_out0 (demux_out0),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .demux_out1 (demux_out1),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .occ0       (occ0),
        .occ1       (occ1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int sent;
        int rcvd;

        // Reset with garbage on the inputs
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        choose     = 1'b1;
        demux_in   = 17'h1FFFF;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        step();
        step();
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_occ0", 32'(occ0), 32'd0);
        chk("rst_occ1", 32'(occ1), 32'd0);
        chk("rst_v0", 32'(out0_valid), 32'd0);
        chk("rst_v1", 32'(out1_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out0_zero", 32'(demux_out0), 32'd0);
        chk("rst_out1_zero", 32'(demux_out1), 32'd0);

        // Steering
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        choose     = 1'b0;
        demux_in   = 17'h00001;
        step();
        choose   = 1'b1;
        demux_in = 17'h10002;
        #1;
        chk("steer_v0", 32'(out0_valid), 32'd1);
        chk("steer_out0", 32'(demux_out0), 32'h00001);
        chk("steer_v1_empty", 32'(out1_valid), 32'd0);
        step();
        in_valid = 1'b0;
        #1;
        chk("steer_v0_drop", 32'(out0_valid), 32'd0);
        chk("steer_v1", 32'(out1_valid), 32'd1);
        chk("steer_out1", 32'(demux_out1), 32'h10002);
        step();
        chk("steer_v1_drop", 32'(out1_valid), 32'd0);
        chk("steer_occ1", 32'(occ1), 32'd0);

        // Full and backpressure on channel 0
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        choose     = 1'b0;
        demux_in   = 17'h0000A;
        step();
        demux_in = 17'h0000B;
        step();
        chk("full_occ0", 32'(occ0), 32'd2);
        chk("full_in_ready0", 32'(in_ready), 32'd0);
        demux_in = 17'h000DD;
        step();
        chk("full_no_push", 32'(occ0), 32'd2);
        choose   = 1'b1;
        demux_in = 17'h0000C;
        #1;
        chk("full_in_ready1", 32'(in_ready), 32'd1);
        step();
        chk("bp_occ1", 32'(occ1), 32'd1);
        chk("bp_out1", 32'(demux_out1), 32'h0000C);
        chk("bp_occ0_kept", 32'(occ0), 32'd2);
        // Pop while full must not open a pass-through slot
        out0_ready = 1'b1;
        choose     = 1'b0;
        demux_in   = 17'h000EE;
        #1;
        chk("full_pop_no_pass", 32'(in_ready), 32'd0);
        chk("drain_head_a", 32'(demux_out0), 32'h0000A);
        step();
        in_valid = 1'b0;
        #1;
        chk("drain_head_b", 32'(demux_out0), 32'h0000B);
        chk("drain_occ0_1", 32'(occ0), 32'd1);
        step();
        chk("drain_empty", 32'(out0_valid), 32'd0);
        chk("drain_occ0_0", 32'(occ0), 32'd0);
        out0_ready = 1'b0;

        // Simultaneous push/pop on channel 1
        out1_ready = 1'b1;
        step();
        chk("pp_pre_drain", 32'(occ1), 32'd0);
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        choose     = 1'b1;
        demux_in   = 17'h00111;
        step();
        chk("pp_occ1_one", 32'(occ1), 32'd1);
        chk("pp_head_111", 32'(demux_out1), 32'h00111);
        demux_in   = 17'h00222;
        out1_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        chk("pp_occ1_same", 32'(occ1), 32'd1);
        chk("pp_head_222", 32'(demux_out1), 32'h00222);
        step();
        chk("pp_final_empty", 32'(occ1), 32'd0);
        out1_ready = 1'b0;

        // Wrap-around with toggling consumer
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 60 && rcvd < 10; cyc++) begin
            choose     = 1'b0;
            in_valid   = (sent < 10);
            demux_in   = 17'(sent);
            out0_ready = ((cyc % 2) == 0);
            #1;
            if (out0_valid && out0_ready) begin
                chk("wrap_word", 32'(demux_out0), 32'(rcvd));
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            chk("wrap_occ_le2", 32'(occ0 <= 2'd2), 32'd1);
            step();
        end
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        chk("wrap_count", 32'(rcvd), 32'd10);

        // Reset mid-operation with both FIFOs full
        in_valid = 1'b1;
        choose   = 1'b0;
        demux_in = 17'h00123;
        step();
        demux_in = 17'h00124;
        step();
        choose   = 1'b1;
        demux_in = 17'h00125;
        step();
        demux_in = 17'h00126;
        step();
        in_valid = 1'b0;
        chk("mid_full0", 32'(occ0), 32'd2);
        chk("mid_full1", 32'(occ1), 32'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_occ0", 32'(occ0), 32'd0);
        chk("mid_occ1", 32'(occ1), 32'd0);
        chk("mid_v0", 32'(out0_valid), 32'd0);
        chk("mid_v1", 32'(out1_valid), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        choose   = 1'b0;
        demux_in = 17'h00F0F;
        step();
        in_valid = 1'b0;
        #1;
        chk("mid_first_v0", 32'(out0_valid), 32'd1);
        chk("mid_first_word", 32'(demux_out0), 32'h00F0F);
        chk("mid_first_occ0", 32'(occ0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
